// File: rtl/if_id_pkg.sv
// Shared types and constants for the IF/ID instruction queue.
// Both NOP encodings decode to legal opcodes (111000 / 101101).
package if_id_pkg;
  localparam int INSTR_W_C = 32;
  localparam int PC_W_C    = 32;

  localparam logic [31:0] NOP_FLUSH_C = 32'hE000_0000;
  localparam logic [31:0] NOP_IDLE_C  = 32'hB400_0000;

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  typedef struct packed {
    logic [INSTR_W_C-1:0] instr;
    logic [PC_W_C-1:0]    pc;
  } if_id_entry_t;
endpackage

// File: rtl/if_id_queue_mem.sv
// Storage array for the IF/ID queue: one synchronous write port, one
// asynchronous read port. Data is not reset; validity is tracked by the top.
module if_id_queue_mem #(
  parameter int W     = 64,
  parameter int DEPTH = 2,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_ptr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] rd_ptr,
  output logic [W-1:0]  rd_data
);
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
endmodule

// File: rtl/if_id_queue.sv
// DEPTH-entry instruction/PC queue between fetch and decode with flush,
// halt-with-drain and resume. Decode always sees a legal opcode.
module if_id_queue
  import if_id_pkg::*;
#(
  parameter int                 INSTR_W   = INSTR_W_C,
  parameter int                 PC_W      = PC_W_C,
  parameter int                 DEPTH     = 2,
  parameter logic [INSTR_W-1:0] NOP_FLUSH = NOP_FLUSH_C,
  parameter logic [INSTR_W-1:0] NOP_IDLE  = NOP_IDLE_C
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [INSTR_W-1:0]       instr_in,
  input  logic [PC_W-1:0]          pc_in,
  input  logic                     flush,
  input  logic                     halt,
  input  logic                     resume,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [INSTR_W-1:0]       instr_out,
  output logic [PC_W-1:0]          pc_out,
  output logic                     out_flushed,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     halted
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [CW-1:0]           count_q, count_nx;
  state_t                  state_q;
  logic                    flushed_q;
  logic [PC_W-1:0]         last_pc_q;
  logic                    push, pop;
  logic [INSTR_W+PC_W-1:0] rd_data;

  // Ready looks only at registered state and flush, never at out_ready.
  assign in_ready  = (state_q == RUN) & (count_q < FULL) & ~flush;
  assign out_valid = (count_q != '0) & ~flush & (state_q != HALTED);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    count_nx = count_q;
    if (flush)            count_nx = '0;
    else if (push & ~pop) count_nx = count_q + CW'(1);
    else if (pop & ~push) count_nx = count_q - CW'(1);
  end

  if_id_queue_mem #(
    .W     (INSTR_W + PC_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_ptr  (wr_ptr),
    .wr_data ({instr_in, pc_in}),
    .rd_ptr  (rd_ptr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      state_q   <= RUN;
      flushed_q <= 1'b0;
      last_pc_q <= '0;
    end else begin
      count_q <= count_nx;
      if (flush) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        flushed_q <= 1'b1;
      end else begin
        if (push) begin
          wr_ptr    <= wr_ptr + AW'(1);
          flushed_q <= 1'b0;
          last_pc_q <= pc_in;
        end
        if (pop) rd_ptr <= rd_ptr + AW'(1);
      end
      // Halt goes straight to HALTED when nothing will be left to drain.
      case (state_q)
        RUN:     if (halt) state_q <= (count_nx == '0) ? HALTED : DRAIN;
        DRAIN:   if (count_nx == '0) state_q <= HALTED;
        HALTED:  if (resume) state_q <= RUN;
        default: state_q <= RUN;
      endcase
    end
  end

  assign halted      = (state_q == HALTED);
  assign out_flushed = ~out_valid & flushed_q & ~halted;
  assign instr_out   = out_valid   ? rd_data[INSTR_W+PC_W-1:PC_W] :
                       out_flushed ? NOP_FLUSH : NOP_IDLE;
  assign pc_out      = out_valid ? rd_data[PC_W-1:0] : last_pc_q;
  assign count       = count_q;
endmodule
